// File: rtl/key_step_conditioner_if.sv
// Button-side bundle for key_step_conditioner: raw key and repeat enable in,
// debounced level and single-cycle event pulses out.
interface key_step_conditioner_if;
  logic key_n;
  logic repeat_en;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic step_pulse;

  modport master (
    output key_n, repeat_en,
    input  pressed, press_pulse, release_pulse, step_pulse
  );

  modport slave (
    input  key_n, repeat_en,
    output pressed, press_pulse, release_pulse, step_pulse
  );
endinterface

// File: rtl/key_step_conditioner.sv
// Synchronises and debounces an active-low push button, then emits a clean level
// plus press/release/step pulses, with optional auto-repeat while held.
module key_step_conditioner #(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic                  clk,
  input  logic                  clr,
  key_step_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             key_s;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;

  assign key_s = ~sync2_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= bus.key_n;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
    end
  end

  // Every state change clears the shared counter so each phase times from zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (bus.repeat_en) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = REPEAT;
            cnt_d   = '0;
            step_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      REPEAT: begin
        if (!key_s) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (!bus.repeat_en) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d  = '0;
          step_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DEB_RELEASE: begin
        // A bounce back to pressed restarts hold timing from scratch.
        if (key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    pressed_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == DEB_RELEASE);
  end

  assign bus.pressed       = pressed_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.step_pulse    = step_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses and level probes by cycle;
// a negedge monitor compares them against the outputs {pressed,press,release,step}.
module tb_key_step_conditioner;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int LAT  = DEB + 3;  // drive cycle -> pulse-visible cycle

  typedef struct {
    int         cyc;
    logic [3:0] v;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  key_step_conditioner_if bus ();

  key_step_conditioner #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (8)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  exp_t pq[$];
  exp_t lq[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void exp_pulse(int c, logic [3:0] v, string nm);
    exp_t x;
    x.cyc = c; x.v = v; x.name = nm;
    pq.push_back(x);
  endfunction

  function automatic void probe(int c, logic [3:0] v, string nm);
    exp_t x;
    x.cyc = c; x.v = v; x.name = nm;
    lq.push_back(x);
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse pops the pulse queue; probes fire on their cycle.
  always @(negedge clk) begin
    logic [3:0] obs;
    obs = {bus.pressed, bus.press_pulse, bus.release_pulse, bus.step_pulse};
    if (obs[2:0] != 3'b000) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got cyc=%0d out=%b, want no pulse", cyc, obs);
      end else begin
        e = pq.pop_front();
        if (e.cyc != cyc || e.v != obs) begin
          errors++;
          $display("FAIL %s: got cyc=%0d out=%b, want cyc=%0d out=%b",
                   e.name, cyc, obs, e.cyc, e.v);
        end
      end
    end
    if (lq.size() > 0 && lq[0].cyc <= cyc) begin
      e = lq.pop_front();
      checks++;
      if (e.cyc != cyc || e.v != obs) begin
        errors++;
        $display("FAIL %s: got cyc=%0d out=%b, want cyc=%0d out=%b",
                 e.name, cyc, obs, e.cyc, e.v);
      end
    end
    if (done) begin
      checks++;
      if (pq.size() != 0 || lq.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations: got %0d pulses %0d probes pending, want 0 0",
                 pq.size(), lq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    int n, p, r;
    clr           = 1'b1;
    bus.key_n     = 1'b1;
    bus.repeat_en = 1'b0;
    probe(2, 4'b0000, "reset_outputs");
    tick(3);
    clr = 1'b0;
    tick(2);

    // Clean press, held with repeat disabled, then clean release.
    n = cyc;
    bus.key_n = 1'b0;
    probe(n + LAT - 1, 4'b0000, "pre_press1");
    exp_pulse(n + LAT, 4'b1101, "press1");
    probe(n + LAT + 30, 4'b1000, "held_no_repeat");
    tick(LAT + 40);
    n = cyc;
    bus.key_n = 1'b1;
    probe(n + LAT - 1, 4'b1000, "pre_release1");
    exp_pulse(n + LAT, 4'b0010, "release1");
    probe(n + LAT + 1, 4'b0000, "idle_after_release1");
    tick(LAT + 5);

    // Two-cycle glitch must be rejected.
    n = cyc;
    bus.key_n = 1'b0;
    tick(2);
    bus.key_n = 1'b1;
    probe(n + 12, 4'b0000, "glitch_rejected");
    tick(15);

    // Press bounce: low 3, high 1, then steady low.
    bus.key_n = 1'b0;
    tick(3);
    bus.key_n = 1'b1;
    tick(1);
    n = cyc;
    bus.key_n = 1'b0;
    exp_pulse(n + LAT, 4'b1101, "press_bounce");
    tick(LAT + 3);
    n = cyc;
    bus.key_n = 1'b1;
    exp_pulse(n + LAT, 4'b0010, "release3");
    tick(LAT + 5);

    // Auto-repeat, then a bouncy release (high 2, low 1, steady high).
    bus.repeat_en = 1'b1;
    n = cyc;
    p = n + LAT;
    bus.key_n = 1'b0;
    exp_pulse(p, 4'b1101, "press_rep");
    exp_pulse(p + HOLD, 4'b1001, "rep1");
    exp_pulse(p + HOLD + REP, 4'b1001, "rep2");
    exp_pulse(p + HOLD + 2 * REP, 4'b1001, "rep3");
    tick(LAT + 38);
    bus.key_n = 1'b1;
    tick(2);
    bus.key_n = 1'b0;
    tick(1);
    n = cyc;
    bus.key_n = 1'b1;
    probe(n + LAT - 1, 4'b1000, "pressed_before_release");
    exp_pulse(n + LAT, 4'b0010, "release_bounce");
    probe(n + LAT + 1, 4'b0000, "idle_after_release_bounce");
    tick(LAT + 5);

    // Clear asserted mid-repeat with the key still held.
    n = cyc;
    p = n + LAT;
    bus.key_n = 1'b0;
    exp_pulse(p, 4'b1101, "press_rst");
    exp_pulse(p + HOLD, 4'b1001, "rep_before_clr");
    tick(LAT + HOLD + 4);
    clr = 1'b1;
    r = cyc + 1;
    probe(r, 4'b0000, "outputs_after_clr");
    tick(1);
    clr = 1'b0;
    probe(r + LAT - 1, 4'b0000, "pre_press_after_clr");
    exp_pulse(r + LAT, 4'b1101, "press_after_clr");
    tick(LAT + 5);
    n = cyc;
    bus.key_n = 1'b1;
    exp_pulse(n + LAT, 4'b0010, "release6");
    tick(LAT + 5);

    done = 1'b1;
    tick(5);
    $display("FAIL summary_not_reached: got monitor still running, want finish");
    $fatal(1);
  end

endmodule
